// File: rtl/cp0_unit.sv
// CP0 coprocessor: architectural state, MTC0/MFC0, exception/ERET commit, vector and interrupt generation.
// MFC0 reads and the vector are combinational; all writes land on the next clk edge. Nothing stalls.
module cp0_unit #(
    parameter int          TLB_ENTRIES = 16,
    parameter int          COUNT_DIV   = 2,
    parameter logic [31:0] PRID_VALUE  = 32'h00004220,
    parameter int          TIMER_IP    = 7,
    localparam int         IDX_W       = $clog2(TLB_ENTRIES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       int_i,
    input  logic             we_i,
    input  logic [4:0]       waddr_i,
    input  logic [2:0]       wsel_i,
    input  logic [31:0]      wdata_i,
    input  logic [4:0]       raddr_i,
    input  logic [2:0]       rsel_i,
    output logic [31:0]      rdata_o,
    input  logic             exc_valid_i,
    input  logic [4:0]       exc_code_i,
    input  logic [31:0]      exc_pc_i,
    input  logic             exc_bd_i,
    input  logic [31:0]      exc_badvaddr_i,
    input  logic             exc_badvaddr_we_i,
    input  logic             eret_i,
    output logic [31:0]      exc_vector_o,
    output logic             int_pending_o,
    output logic             timer_int_o,
    output logic [31:0]      status_o,
    output logic [31:0]      cause_o,
    output logic [31:0]      epc_o,
    output logic [IDX_W-1:0] random_o,
    output logic [IDX_W-1:0] index_o
);
    localparam logic [IDX_W-1:0] RAND_MAX  = IDX_W'(TLB_ENTRIES - 1);
    localparam logic             PRESC_MAX = 1'(COUNT_DIV - 1);

    logic [IDX_W-1:0] r_index, r_random, r_wired;
    logic [31:0]      r_badvaddr, r_count, r_compare, r_epc;
    logic             r_presc, r_ti;
    logic             r_bev, r_exl, r_ie;
    logic [7:0]       r_im;
    logic             r_bd, r_iv;
    logic [5:0]       r_ip_hw;
    logic [1:0]       r_ip_sw;
    logic [4:0]       r_exccode;
    logic [17:0]      r_ebase;

    logic w_wr_index, w_wr_wired, w_wr_count, w_wr_compare;
    logic w_wr_status, w_wr_cause, w_wr_epc, w_wr_ebase, w_cnt_inc;
    logic [7:0]  w_ti_mask, w_ip;
    logic [31:0] w_ebase, w_base, w_off;
    logic        w_unused;

    assign w_wr_index   = we_i && waddr_i == 5'd0  && wsel_i == 3'd0;
    assign w_wr_wired   = we_i && waddr_i == 5'd6  && wsel_i == 3'd0;
    assign w_wr_count   = we_i && waddr_i == 5'd9  && wsel_i == 3'd0;
    assign w_wr_compare = we_i && waddr_i == 5'd11 && wsel_i == 3'd0;
    assign w_wr_status  = we_i && waddr_i == 5'd12 && wsel_i == 3'd0;
    assign w_wr_cause   = we_i && waddr_i == 5'd13 && wsel_i == 3'd0;
    assign w_wr_epc     = we_i && waddr_i == 5'd14 && wsel_i == 3'd0;
    assign w_wr_ebase   = we_i && waddr_i == 5'd15 && wsel_i == 3'd1;
    assign w_cnt_inc    = (r_presc == PRESC_MAX) && !w_wr_count;

    assign w_ti_mask = r_ti ? (8'b1 << TIMER_IP) : 8'b0;
    assign w_ip      = {r_ip_hw, r_ip_sw} | w_ti_mask;
    assign w_ebase   = {2'b10, r_ebase, 12'h000};
    assign w_unused  = &{1'b0, wdata_i};

    assign status_o      = {9'b0, r_bev, 6'b0, r_im, 6'b0, r_exl, r_ie};
    assign cause_o       = {r_bd, r_ti, 6'b0, r_iv, 7'b0, w_ip, 1'b0, r_exccode, 2'b00};
    assign epc_o         = r_epc;
    assign random_o      = r_random;
    assign index_o       = r_index;
    assign timer_int_o   = r_ti;
    assign int_pending_o = r_ie && !r_exl && |(w_ip & r_im);

    assign w_base       = r_bev ? 32'hBFC00200 : w_ebase;
    assign w_off        = (exc_code_i == 5'd0 && r_iv) ? 32'h200 : 32'h180;
    assign exc_vector_o = (eret_i && !exc_valid_i) ? r_epc : w_base + w_off;

    always_comb begin
        rdata_o = 32'h0;
        case ({raddr_i, rsel_i})
            {5'd0,  3'd0}: rdata_o = 32'(r_index);
            {5'd1,  3'd0}: rdata_o = 32'(r_random);
            {5'd6,  3'd0}: rdata_o = 32'(r_wired);
            {5'd8,  3'd0}: rdata_o = r_badvaddr;
            {5'd9,  3'd0}: rdata_o = r_count;
            {5'd11, 3'd0}: rdata_o = r_compare;
            {5'd12, 3'd0}: rdata_o = status_o;
            {5'd13, 3'd0}: rdata_o = cause_o;
            {5'd14, 3'd0}: rdata_o = r_epc;
            {5'd15, 3'd0}: rdata_o = PRID_VALUE;
            {5'd15, 3'd1}: rdata_o = w_ebase;
            {5'd16, 3'd0}: rdata_o = 32'h80000000;
            default:       rdata_o = 32'h0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_index    <= '0;
            r_random   <= RAND_MAX;
            r_wired    <= '0;
            r_badvaddr <= '0;
            r_count    <= '0;
            r_compare  <= '0;
            r_epc      <= '0;
            r_presc    <= 1'b0;
            r_ti       <= 1'b0;
            r_bev      <= 1'b1;
            r_exl      <= 1'b0;
            r_ie       <= 1'b0;
            r_im       <= '0;
            r_bd       <= 1'b0;
            r_iv       <= 1'b0;
            r_ip_hw    <= '0;
            r_ip_sw    <= '0;
            r_exccode  <= '0;
            r_ebase    <= '0;
        end else begin
            r_ip_hw <= int_i;
            if (w_wr_index)   r_index   <= wdata_i[IDX_W-1:0];
            if (w_wr_wired)   r_wired   <= wdata_i[IDX_W-1:0];
            if (w_wr_compare) r_compare <= wdata_i;
            if (w_wr_ebase)   r_ebase   <= wdata_i[29:12];

            if (w_wr_wired || r_random <= r_wired) r_random <= RAND_MAX;
            else                                   r_random <= r_random - 1'b1;

            if (w_wr_count) begin
                r_count <= wdata_i;
                r_presc <= 1'b0;
            end else if (w_cnt_inc) begin
                r_count <= r_count + 32'd1;
                r_presc <= 1'b0;
            end else begin
                r_presc <= r_presc + 1'b1;
            end

            // Compare write clears TI even if the timer matches this cycle
            if (w_wr_compare)                                  r_ti <= 1'b0;
            else if (w_cnt_inc && r_count + 32'd1 == r_compare) r_ti <= 1'b1;

            if (w_wr_status) begin
                r_bev <= wdata_i[22];
                r_im  <= wdata_i[15:8];
                r_ie  <= wdata_i[0];
            end
            if (w_wr_cause) begin
                r_iv    <= wdata_i[23];
                r_ip_sw <= wdata_i[9:8];
            end

            if (exc_valid_i)      r_exl <= 1'b1;
            else if (eret_i)      r_exl <= 1'b0;
            else if (w_wr_status) r_exl <= wdata_i[1];

            // Nested exceptions (EXL already set) keep the original EPC/BD
            if (exc_valid_i && !r_exl) begin
                r_epc <= exc_bd_i ? exc_pc_i - 32'd4 : exc_pc_i;
                r_bd  <= exc_bd_i;
            end else if (w_wr_epc) begin
                r_epc <= wdata_i;
            end
            if (exc_valid_i)                       r_exccode  <= exc_code_i;
            if (exc_valid_i && exc_badvaddr_we_i)  r_badvaddr <= exc_badvaddr_i;
        end
    end
endmodule

// File: tb/tb_cp0_unit.sv
// Directed bench for cp0_unit: hand-computed vectors checked with immediate assertions.
`timescale 1ns/1ps
module tb_cp0_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  int_i;
    logic        we_i;
    logic [4:0]  waddr_i;
    logic [2:0]  wsel_i;
    logic [31:0] wdata_i;
    logic [4:0]  raddr_i;
    logic [2:0]  rsel_i;
    logic [31:0] rdata_o;
    logic        exc_valid_i;
    logic [4:0]  exc_code_i;
    logic [31:0] exc_pc_i;
    logic        exc_bd_i;
    logic [31:0] exc_badvaddr_i;
    logic        exc_badvaddr_we_i;
    logic        eret_i;
    logic [31:0] exc_vector_o;
    logic        int_pending_o;
    logic        timer_int_o;
    logic [31:0] status_o, cause_o, epc_o;
    logic [3:0]  random_o, index_o;

    int n_chk = 0;
    int n_err = 0;

    cp0_unit #(
        .TLB_ENTRIES(16), .COUNT_DIV(2), .PRID_VALUE(32'h00004220), .TIMER_IP(7)
    ) dut (
        .clk(clk), .rst(rst), .int_i(int_i),
        .we_i(we_i), .waddr_i(waddr_i), .wsel_i(wsel_i), .wdata_i(wdata_i),
        .raddr_i(raddr_i), .rsel_i(rsel_i), .rdata_o(rdata_o),
        .exc_valid_i(exc_valid_i), .exc_code_i(exc_code_i), .exc_pc_i(exc_pc_i),
        .exc_bd_i(exc_bd_i), .exc_badvaddr_i(exc_badvaddr_i),
        .exc_badvaddr_we_i(exc_badvaddr_we_i), .eret_i(eret_i),
        .exc_vector_o(exc_vector_o), .int_pending_o(int_pending_o),
        .timer_int_o(timer_int_o), .status_o(status_o), .cause_o(cause_o),
        .epc_o(epc_o), .random_o(random_o), .index_o(index_o)
    );

    always #10 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic rd(input string tag, input logic [4:0] a, input logic [2:0] s,
                      input logic [31:0] exp);
        raddr_i = a;
        rsel_i  = s;
        #1;
        chk(tag, rdata_o, exp);
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [2:0] s, input logic [31:0] d);
        we_i    = 1'b1;
        waddr_i = a;
        wsel_i  = s;
        wdata_i = d;
        tick();
        we_i = 1'b0;
    endtask

    initial begin
        rst = 1'b1; int_i = '0; we_i = 1'b0; waddr_i = '0; wsel_i = '0; wdata_i = '0;
        raddr_i = '0; rsel_i = '0; exc_valid_i = 1'b0; exc_code_i = '0; exc_pc_i = '0;
        exc_bd_i = 1'b0; exc_badvaddr_i = '0; exc_badvaddr_we_i = 1'b0; eret_i = 1'b0;
        tick();
        tick();

        // Reset state
        rd("rst_status", 5'd12, 3'd0, 32'h00400000);
        rd("rst_ebase", 5'd15, 3'd1, 32'h80000000);
        rd("rst_prid", 5'd15, 3'd0, 32'h00004220);
        rd("rst_config", 5'd16, 3'd0, 32'h80000000);
        rd("unlisted_reg", 5'd3, 3'd0, 32'h0);
        chk("rst_random", 32'(random_o), 32'd15);
        chk("rst_vector", exc_vector_o, 32'hBFC00380);

        // Random free-runs 15..0 and wraps to 15 with Wired=0
        rst = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            tick();
            chk("random_walk", 32'(random_o), 32'((15 - i) & 15));
        end

        // Wired=4: read during write returns old value; Random reloads then cycles 15..4
        raddr_i = 5'd6; rsel_i = 3'd0;
        we_i = 1'b1; waddr_i = 5'd6; wsel_i = 3'd0; wdata_i = 32'd4;
        #1;
        chk("wired_read_old", rdata_o, 32'h0);
        tick();
        we_i = 1'b0;
        chk("random_after_wired", 32'(random_o), 32'd15);
        rd("wired_read_new", 5'd6, 3'd0, 32'd4);
        for (int i = 1; i <= 12; i++) begin
            tick();
            chk("random_wired", 32'(random_o), (i <= 11) ? 32'(15 - i) : 32'd15);
        end
        mtc0(5'd0, 3'd0, 32'h25);
        chk("index_mask", 32'(index_o), 32'd5);

        // Timer: Count=10, Compare=12, Count increments every 2 cycles
        mtc0(5'd11, 3'd0, 32'd12);
        mtc0(5'd9, 3'd0, 32'd10);
        repeat (3) tick();
        chk("ti_before_match", 32'(timer_int_o), 32'd0);
        tick();
        chk("ti_at_match", 32'(timer_int_o), 32'd1);
        chk("cause_ti_ip7", cause_o, 32'h40008000);
        rd("count_at_match", 5'd9, 3'd0, 32'd12);
        tick();
        tick();
        chk("ti_holds", 32'(timer_int_o), 32'd1);
        mtc0(5'd11, 3'd0, 32'd12);
        chk("ti_cleared", 32'(timer_int_o), 32'd0);
        mtc0(5'd9, 3'd0, 32'd10);
        repeat (3) tick();
        mtc0(5'd11, 3'd0, 32'd12);
        chk("ti_clear_wins", 32'(timer_int_o), 32'd0);
        rd("count_clear_wins", 5'd9, 3'd0, 32'd12);

        // Syscall in delay slot with EXL=0
        exc_valid_i = 1'b1; exc_code_i = 5'd8; exc_pc_i = 32'h80001004; exc_bd_i = 1'b1;
        #1;
        chk("vec_sys_bev", exc_vector_o, 32'hBFC00380);
        tick();
        exc_valid_i = 1'b0;
        chk("epc_bd", epc_o, 32'h80001000);
        chk("cause_sys", cause_o, 32'h80000020);
        chk("status_exl", status_o, 32'h00400002);

        // Nested exception: EPC/BD kept, ExcCode and BadVAddr updated
        exc_valid_i = 1'b1; exc_code_i = 5'd10; exc_pc_i = 32'h80002000; exc_bd_i = 1'b0;
        exc_badvaddr_i = 32'h00001234; exc_badvaddr_we_i = 1'b1;
        tick();
        exc_valid_i = 1'b0; exc_badvaddr_we_i = 1'b0;
        chk("epc_nested", epc_o, 32'h80001000);
        chk("cause_nested", cause_o, 32'h80000028);
        rd("badvaddr", 5'd8, 3'd0, 32'h00001234);

        // EBase fixed bits, then relocated vector with IV
        mtc0(5'd15, 3'd1, 32'hFFFFFFFF);
        rd("ebase_mask", 5'd15, 3'd1, 32'hBFFFF000);
        mtc0(5'd15, 3'd1, 32'h80010000);
        rd("ebase_write", 5'd15, 3'd1, 32'h80010000);
        mtc0(5'd12, 3'd0, 32'h00000401);
        chk("status_write", status_o, 32'h00000401);
        mtc0(5'd13, 3'd0, 32'h00800000);
        chk("cause_iv_write", cause_o, 32'h80800028);
        int_i = 6'b000001;
        tick();
        chk("int_pending_on", 32'(int_pending_o), 32'd1);
        exc_valid_i = 1'b1; exc_code_i = 5'd0; exc_pc_i = 32'h80003000; exc_bd_i = 1'b0;
        #1;
        chk("vec_int_ebase", exc_vector_o, 32'h80010200);
        tick();
        exc_valid_i = 1'b0;
        chk("status_int_exl", status_o, 32'h00000403);
        chk("epc_int", epc_o, 32'h80003000);
        chk("cause_int", cause_o, 32'h00800400);
        chk("int_pending_masked", 32'(int_pending_o), 32'd0);

        // ERET: vector is EPC, EXL clears on the next edge
        int_i = 6'b0; eret_i = 1'b1;
        #1;
        chk("vec_eret", exc_vector_o, 32'h80003000);
        tick();
        eret_i = 1'b0;
        chk("status_eret", status_o, 32'h00000401);

        // Exception + ERET + MTC0 Status together
        exc_valid_i = 1'b1; eret_i = 1'b1; exc_code_i = 5'd12; exc_pc_i = 32'h80004000;
        we_i = 1'b1; waddr_i = 5'd12; wsel_i = 3'd0; wdata_i = 32'h00000001;
        #1;
        chk("vec_exc_over_eret", exc_vector_o, 32'h80010180);
        tick();
        exc_valid_i = 1'b0; eret_i = 1'b0; we_i = 1'b0;
        chk("status_combo", status_o, 32'h00000003);
        chk("epc_combo", epc_o, 32'h80004000);
        chk("cause_combo", cause_o, 32'h00800030);

        // Reset mid-sequence discards same-cycle write and exception
        rst = 1'b1;
        we_i = 1'b1; waddr_i = 5'd12; wdata_i = 32'hFFFFFFFF;
        exc_valid_i = 1'b1; exc_code_i = 5'd8;
        tick();
        we_i = 1'b0; exc_valid_i = 1'b0;
        chk("rst2_status", status_o, 32'h00400000);
        chk("rst2_cause", cause_o, 32'h0);
        chk("rst2_epc", epc_o, 32'h0);
        chk("rst2_random", 32'(random_o), 32'd15);
        chk("rst2_index", 32'(index_o), 32'd0);
        chk("rst2_ti", 32'(timer_int_o), 32'd0);
        rd("rst2_ebase", 5'd15, 3'd1, 32'h80000000);
        rd("rst2_count", 5'd9, 3'd0, 32'h0);
        rd("rst2_badvaddr", 5'd8, 3'd0, 32'h0);
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
